// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a classic five-stage pipeline.
// Generates the stage-register enables, flush and bubble controls for
// branches, load-use hazards, multi-cycle multiplies and memory stalls.
// It also keeps a sticky memory-timeout flag and a stall-cycle counter.
module pipe_hazard_ctrl #(
   parameter int MUL_CYCLES  = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic        id_is_mul,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        branch_taken,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        mul_busy,
   output logic        mem_err,
   output logic [15:0] stall_cycles
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      MUL_BUSY = 2'd2,
      MEM_WAIT = 2'd3
   } state_t;

   // The multiply stays MUL_CYCLES cycles in EX: the issue cycle plus
   // MUL_CYCLES-1 busy cycles counted down by mul_cnt.
   localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_CYCLES - 1);
   localparam logic [7:0] TIMEOUT_VAL  = 8'(MEM_TIMEOUT);
   localparam logic [7:0] WAIT_MAX     = 8'hFF;

   state_t      state;
   state_t      state_next;
   state_t      saved_state;
   logic [3:0]  mul_cnt;
   logic [7:0]  wait_cnt;
   logic [7:0]  wait_cnt_inc;

   logic        mem_stall;
   logic        load_use;
   logic        mul_issue;

   assign mem_stall    = mem_req && !mem_ready;
   assign wait_cnt_inc = wait_cnt + 8'd1;

   // Load-use hazard: the load in EX writes a register the ID instruction reads.
   // Register 0 never carries a dependency.
   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

   // Combinational decode of stage controls and next state.
   // Priority in RUN: memory stall, then branch, then load-use, then multiply issue.
   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      mul_busy    = 1'b0;
      mul_issue   = 1'b0;
      state_next  = state;

      case (state)
         IDLE: begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_next  = RUN;
         end

         RUN: begin
            if (mem_stall) begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_en    = 1'b0;
               exmem_en   = 1'b0;
               state_next = MEM_WAIT;
            end else if (branch_taken) begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
            end else if (load_use) begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_bubble = 1'b1;
            end else if (id_is_mul) begin
               mul_issue  = 1'b1;
               state_next = MUL_BUSY;
            end
         end

         MUL_BUSY: begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            mul_busy = 1'b1;
            if (mem_stall) begin
               exmem_en   = 1'b0;
               state_next = MEM_WAIT;
            end else if (mul_cnt == 4'd1) begin
               state_next = RUN;
            end
         end

         MEM_WAIT: begin
            if (mem_ready) begin
               // Completion cycle behaves like the state being returned to.
               state_next = saved_state;
               if (saved_state == MUL_BUSY) begin
                  pc_en    = 1'b0;
                  ifid_en  = 1'b0;
                  idex_en  = 1'b0;
                  mul_busy = 1'b1;
               end
            end else begin
               pc_en    = 1'b0;
               ifid_en  = 1'b0;
               idex_en  = 1'b0;
               exmem_en = 1'b0;
               mul_busy = (saved_state == MUL_BUSY);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, counters, saved return state, timeout flag and stall statistics.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         saved_state  <= RUN;
         mul_cnt      <= 4'd0;
         wait_cnt     <= 8'd0;
         mem_err      <= 1'b0;
         stall_cycles <= 16'd0;
      end else begin
         state <= state_next;

         if (!pc_en && (state != IDLE)) begin
            stall_cycles <= stall_cycles + 16'd1;
         end

         case (state)
            RUN, MUL_BUSY: begin
               if (mem_stall) begin
                  saved_state <= state;
                  wait_cnt    <= 8'd1;
                  if (TIMEOUT_VAL == 8'd1) begin
                     mem_err <= 1'b1;
                  end
               end else if (mul_issue) begin
                  mul_cnt <= MUL_CNT_INIT;
               end else if (state == MUL_BUSY) begin
                  mul_cnt <= mul_cnt - 4'd1;
               end
            end

            MEM_WAIT: begin
               if (!mem_ready && (wait_cnt != WAIT_MAX)) begin
                  wait_cnt <= wait_cnt_inc;
                  if (wait_cnt_inc == TIMEOUT_VAL) begin
                     mem_err <= 1'b1;
                  end
               end
            end

            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

   localparam int MUL_CYCLES  = 4;
   localparam int MEM_TIMEOUT = 15;

   // Output vector order: pc, ifid, idex, exmem, flush, bubble, mul_busy
   localparam logic [6:0] IDLE_OUT   = 7'b0000_110;
   localparam logic [6:0] RUN_OUT    = 7'b1111_000;
   localparam logic [6:0] BUSY_OUT   = 7'b0001_001;
   localparam logic [6:0] BRANCH_OUT = 7'b1111_110;
   localparam logic [6:0] LU_OUT     = 7'b0011_010;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  idRs1 = '0;
   logic [4:0]  idRs2 = '0;
   logic        idUsesRs1 = 1'b0;
   logic        idUsesRs2 = 1'b0;
   logic        idIsMul = 1'b0;
   logic [4:0]  exRd = '0;
   logic        exMemRead = 1'b0;
   logic        branchTaken = 1'b0;
   logic        memReq = 1'b0;
   logic        memReady = 1'b0;
   logic        pcEn, ifidEn, idexEn, exmemEn, ifidFlush, idexBubble, mulBusy, memErr;
   logic [15:0] stallCycles;

   int checkCount = 0;
   int passCount  = 0;

   // Behavioural model: where the pipeline is, described in plain quantities
   bit mIdle;
   bit mWaiting;
   int mMulLeft;
   int mWaitLen;
   bit mErr;
   int mStalls;

   pipe_hazard_ctrl #(.MUL_CYCLES(MUL_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .id_rs1(idRs1), .id_rs2(idRs2),
      .id_uses_rs1(idUsesRs1), .id_uses_rs2(idUsesRs2),
      .id_is_mul(idIsMul), .ex_rd(exRd), .ex_mem_read(exMemRead),
      .branch_taken(branchTaken), .mem_req(memReq), .mem_ready(memReady),
      .pc_en(pcEn), .ifid_en(ifidEn), .idex_en(idexEn), .exmem_en(exmemEn),
      .ifid_flush(ifidFlush), .idex_bubble(idexBubble), .mul_busy(mulBusy),
      .mem_err(memErr), .stall_cycles(stallCycles)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts and reports
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed == expected) passCount++;
      else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
   endtask

   function automatic logic [6:0] outVec();
      return {pcEn, ifidEn, idexEn, exmemEn, ifidFlush, idexBubble, mulBusy};
   endfunction

   task automatic modelReset();
      mIdle    = 1'b1;
      mWaiting = 1'b0;
      mMulLeft = 0;
      mWaitLen = 0;
      mErr     = 1'b0;
      mStalls  = 0;
   endtask

   // Drive one cycle's worth of ID/EX/MEM inputs
   task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic isMul,
                                input logic [4:0] rd, input logic memRd,
                                input logic br, input logic req, input logic rdy);
      idRs1 = rs1; idRs2 = rs2; idUsesRs1 = u1; idUsesRs2 = u2; idIsMul = isMul;
      exRd = rd; exMemRead = memRd; branchTaken = br; memReq = req; memReady = rdy;
   endtask

   task automatic quiet();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Compare one cycle against the model, then advance the model across the edge
   task automatic stepCycle();
      logic [6:0] expV;
      bit luHaz;
      bit wasIdle;
      @(negedge clk);
      checkOutput("mem_err", int'(memErr), int'(mErr));
      checkOutput("stall_cycles", int'(stallCycles), mStalls);
      luHaz = exMemRead && (exRd != 0) &&
              ((idUsesRs1 && idRs1 == exRd) || (idUsesRs2 && idRs2 == exRd));
      wasIdle = mIdle;
      if (mIdle) begin
         expV  = IDLE_OUT;
         mIdle = 1'b0;
      end else if (mWaiting) begin
         if (memReady) begin
            expV     = (mMulLeft > 0) ? BUSY_OUT : RUN_OUT;
            mWaiting = 1'b0;
         end else begin
            expV = {6'b0, mMulLeft > 0};
            if (mWaitLen < 255) begin
               mWaitLen++;
               if (mWaitLen == MEM_TIMEOUT) mErr = 1'b1;
            end
         end
      end else if (memReq && !memReady) begin
         expV     = {6'b0, mMulLeft > 0};
         mWaiting = 1'b1;
         mWaitLen = 1;
         if (MEM_TIMEOUT == 1) mErr = 1'b1;
      end else if (mMulLeft > 0) begin
         expV = BUSY_OUT;
         mMulLeft--;
      end else if (branchTaken) begin
         expV = BRANCH_OUT;
      end else if (luHaz) begin
         expV = LU_OUT;
      end else begin
         expV = RUN_OUT;
         if (idIsMul) mMulLeft = MUL_CYCLES - 1;
      end
      checkOutput("stage_ctrl", int'(outVec()), int'(expV));
      if (!wasIdle && !expV[6]) mStalls = (mStalls + 1) & 16'hFFFF;
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset applied mid-cycle; outputs must go idle at once
   task automatic doReset();
      reset = 1'b1;
      #1;
      modelReset();
      checkOutput("reset_ctrl", int'(outVec()), int'(IDLE_OUT));
      checkOutput("reset_err", int'(memErr), 0);
      checkOutput("reset_stalls", int'(stallCycles), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      modelReset();
      @(posedge clk);
      #1;
      doReset();

      // Clean start: one idle cycle then free flow
      quiet();
      repeat (6) stepCycle();

      // Load-use on rs2, then same pattern with ex_rd=0 (no hazard)
      applyStimulus(5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      stepCycle();
      quiet();
      stepCycle();
      applyStimulus(5'd1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      stepCycle();
      quiet();
      stepCycle();

      // Multiply issue with a branch pulse during the busy cycles
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepCycle();
      quiet();
      stepCycle();
      branchTaken = 1'b1;
      stepCycle();
      quiet();
      repeat (3) stepCycle();

      // Branch together with load-use: branch wins
      applyStimulus(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
      stepCycle();
      quiet();
      stepCycle();

      // Long memory stall while the multiply has two busy cycles left
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepCycle();
      quiet();
      stepCycle();
      memReq = 1'b1;
      repeat (20) stepCycle();
      checkOutput("timeout_flag", int'(memErr), 1);
      memReady = 1'b1;
      stepCycle();
      quiet();
      repeat (4) stepCycle();

      // Randomized traffic with occasional resets
      doReset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) doReset();
         applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 7) == 0), 5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                       1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0));
         stepCycle();
      end

      // Stall counter wrap, then reset in the middle of a memory wait
      doReset();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      stepCycle();
      repeat (65536) stepCycle();
      @(negedge clk);
      checkOutput("stall_wrap", int'(stallCycles), 0);
      checkOutput("wait_err", int'(memErr), 1);
      @(posedge clk);
      #1;
      doReset();
      quiet();
      stepCycle();
      stepCycle();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
